// File: rtl/apb_master_bridge.sv
`default_nettype none
// apb_master_bridge: single-cycle CPU load/store to APB SETUP/ACCESS bridge
// with one-hot slave decode and a PREADY timeout. Rev 1.0
module apb_master_bridge #(
  parameter int         NUM_SLAVES = 4,
  parameter int         SEL_BITS   = 2,
  parameter logic [3:0] APB_REGION = 4'hF,
  parameter int         TIMEOUT    = 16
) (
  input  logic                     PCLK,
  input  logic                     PRESETn,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [15:0]              cpu_addr,
  input  logic [15:0]              cpu_wdata,
  output logic [15:0]              cpu_rdata,
  output logic                     cpu_ready,
  output logic                     cpu_err,
  output logic                     cpu_busy,
  output logic [4:0]               PADDR,
  output logic                     PWRITE,
  output logic [15:0]              PWDATA,
  output logic [NUM_SLAVES-1:0]    PSEL,
  output logic                     PENABLE,
  input  logic [NUM_SLAVES*16-1:0] PRDATA_bus,
  input  logic [NUM_SLAVES-1:0]    PREADY
);

  localparam int              CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t              state;
  logic [SEL_BITS-1:0] idx;
  logic [CNT_W-1:0]    wait_cnt;

  logic [SEL_BITS-1:0] req_idx;
  logic                req_hit;
  logic [15:0]         sel_rdata;
  logic                sel_ready;
  logic                unused_addr_bits;

  assign req_idx = cpu_addr[5+SEL_BITS-1:5];
  assign req_hit = (cpu_addr[15:12] == APB_REGION) &&
                   ({1'b0, req_idx} < (SEL_BITS+1)'(NUM_SLAVES));
  // Address bits between the slave index and the region nibble are don't-care.
  assign unused_addr_bits = ^cpu_addr[11:5+SEL_BITS];

  always_comb begin
    sel_rdata = '0;
    sel_ready = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx == SEL_BITS'(i)) begin
        sel_rdata = PRDATA_bus[i*16 +: 16];
        sel_ready = PREADY[i];
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= IDLE;
      idx       <= '0;
      wait_cnt  <= '0;
      cpu_rdata <= '0;
      cpu_ready <= 1'b0;
      cpu_err   <= 1'b0;
      cpu_busy  <= 1'b0;
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
      PSEL      <= '0;
      PENABLE   <= 1'b0;
    end else begin
      cpu_ready <= 1'b0;
      cpu_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            PADDR    <= cpu_addr[4:0];
            PWRITE   <= cpu_we;
            PWDATA   <= cpu_wdata;
            idx      <= req_idx;
            cpu_busy <= 1'b1;
            if (req_hit) begin
              state    <= SETUP;
              PSEL     <= NUM_SLAVES'(1) << req_idx;
              wait_cnt <= '0;
            end else begin
              // Decode miss: answer straight away, the APB bus stays quiet.
              state     <= RESP;
              cpu_ready <= 1'b1;
              cpu_err   <= 1'b1;
              cpu_rdata <= '0;
            end
          end
        end
        SETUP: begin
          state   <= ACCESS;
          PENABLE <= 1'b1;
        end
        ACCESS: begin
          if (sel_ready) begin
            state     <= RESP;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            cpu_ready <= 1'b1;
            cpu_rdata <= PWRITE ? 16'h0000 : sel_rdata;
          end else if (wait_cnt == CNT_LAST) begin
            state     <= RESP;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            cpu_ready <= 1'b1;
            cpu_err   <= 1'b1;
            cpu_rdata <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          state    <= IDLE;
          cpu_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`default_nettype none
// tb_apb_master_bridge: scoreboard bench for apb_master_bridge with a
// stallable four-slave APB model.
module tb_apb_master_bridge;

  logic        PCLK;
  logic        PRESETn;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_ready;
  logic        cpu_err;
  logic        cpu_busy;
  logic [4:0]  PADDR;
  logic        PWRITE;
  logic [15:0] PWDATA;
  logic [3:0]  PSEL;
  logic        PENABLE;
  logic [63:0] PRDATA_bus;
  logic [3:0]  PREADY;

  logic [15:0] slave_data [4];
  int          stall [4];
  int          waited [4];
  logic [16:0] sb_q [$];
  logic [16:0] sb_e;
  int          n_checks = 0;
  int          n_pass   = 0;

  apb_master_bridge #(
    .NUM_SLAVES (4),
    .SEL_BITS   (2),
    .APB_REGION (4'hF),
    .TIMEOUT    (16)
  ) dut (
    .PCLK       (PCLK),
    .PRESETn    (PRESETn),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_ready  (cpu_ready),
    .cpu_err    (cpu_err),
    .cpu_busy   (cpu_busy),
    .PADDR      (PADDR),
    .PWRITE     (PWRITE),
    .PWDATA     (PWDATA),
    .PSEL       (PSEL),
    .PENABLE    (PENABLE),
    .PRDATA_bus (PRDATA_bus),
    .PREADY     (PREADY)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Slave model: slave i holds PREADY low for stall[i] ACCESS cycles.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      PRDATA_bus[i*16 +: 16] = slave_data[i];
      PREADY[i] = (waited[i] >= stall[i]);
    end
  end

  always @(posedge PCLK) begin
    for (int i = 0; i < 4; i++) begin
      if (!PSEL[i])
        waited[i] <= 0;
      else if (PENABLE && !PREADY[i])
        waited[i] <= waited[i] + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Scoreboard consumer: every completion pulse must match the oldest expectation.
  always @(negedge PCLK) begin
    if (PRESETn && cpu_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_ready", {31'd0, cpu_ready}, 32'd0);
      end else begin
        sb_e = sb_q.pop_front();
        check("sb_rdata", {16'd0, cpu_rdata}, {16'd0, sb_e[16:1]});
        check("sb_err", {31'd0, cpu_err}, {31'd0, sb_e[0]});
      end
    end
  end

  task automatic xfer(input string tag, input logic we, input logic [15:0] addr,
                      input logic [15:0] wdata, input logic [3:0] exp_psel,
                      input logic [15:0] exp_rdata, input logic exp_err,
                      input int exp_access);
    int cyc;
    int acc;
    @(posedge PCLK); #1;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    sb_q.push_back({exp_rdata, exp_err});
    @(posedge PCLK); #1;
    cpu_req = 1'b0;
    if (exp_psel != 4'd0) begin
      check({tag, "_setup_psel"},    {28'd0, PSEL},     {28'd0, exp_psel});
      check({tag, "_setup_penable"}, {31'd0, PENABLE},  32'd0);
      check({tag, "_setup_paddr"},   {27'd0, PADDR},    {27'd0, addr[4:0]});
      check({tag, "_setup_pwrite"},  {31'd0, PWRITE},   {31'd0, we});
      check({tag, "_setup_busy"},    {31'd0, cpu_busy}, 32'd1);
      if (we)
        check({tag, "_setup_pwdata"}, {16'd0, PWDATA}, {16'd0, wdata});
    end
    cyc = 0;
    acc = 0;
    while (!cpu_ready && cyc < 40) begin
      if (PENABLE) acc++;
      if (cyc == 1) begin
        check({tag, "_access_penable"}, {31'd0, PENABLE}, 32'd1);
        check({tag, "_access_psel"},    {28'd0, PSEL},    {28'd0, exp_psel});
      end
      @(posedge PCLK); #1;
      cyc++;
    end
    check({tag, "_ready_seen"},   {31'd0, cpu_ready}, 32'd1);
    check({tag, "_access_cycles"}, acc, exp_access);
    check({tag, "_latency"}, cyc, (exp_psel != 4'd0) ? exp_access + 1 : 0);
    check({tag, "_resp_psel"},    {28'd0, PSEL},    32'd0);
    check({tag, "_resp_penable"}, {31'd0, PENABLE}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int setups;
    int readies;
    int cyc;
    logic sel0_seen;

    slave_data[0] = 16'h1111;
    slave_data[1] = 16'hA5C3;
    slave_data[2] = 16'h5A5A;
    slave_data[3] = 16'h0F0F;
    for (int i = 0; i < 4; i++) stall[i] = 0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = 16'h0000;
    cpu_wdata = 16'h0000;
    PRESETn   = 1'b1;
    #2 PRESETn = 1'b0;
    #2;
    check("rst_psel",    {28'd0, PSEL},      32'd0);
    check("rst_penable", {31'd0, PENABLE},   32'd0);
    check("rst_ready",   {31'd0, cpu_ready}, 32'd0);
    check("rst_err",     {31'd0, cpu_err},   32'd0);
    check("rst_busy",    {31'd0, cpu_busy},  32'd0);
    check("rst_rdata",   {16'd0, cpu_rdata}, 32'd0);
    check("rst_paddr",   {27'd0, PADDR},     32'd0);
    check("rst_pwdata",  {16'd0, PWDATA},    32'd0);
    @(posedge PCLK); @(posedge PCLK); #1;
    PRESETn = 1'b1;

    xfer("st0",  1'b1, 16'hF01E, 16'h00FF, 4'b0001, 16'h0000, 1'b0, 1);
    xfer("ld1",  1'b0, 16'hF03F, 16'h0000, 4'b0010, 16'hA5C3, 1'b0, 1);
    xfer("st1",  1'b1, 16'hF03F, 16'hBEEF, 4'b0010, 16'h0000, 1'b0, 1);
    stall[2] = 3;
    xfer("stall2", 1'b0, 16'hF05F, 16'h0000, 4'b0100, 16'h5A5A, 1'b0, 4);
    stall[3] = 1000;
    xfer("tmo3", 1'b0, 16'hF07F, 16'h0000, 4'b1000, 16'h0000, 1'b1, 16);
    xfer("miss", 1'b0, 16'h1234, 16'h0000, 4'b0000, 16'h0000, 1'b1, 0);

    // Reset in the middle of an ACCESS phase to a dead slave.
    @(posedge PCLK); #1;
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 16'hF07F;
    @(posedge PCLK); #1;
    cpu_req = 1'b0;
    @(posedge PCLK); #1;
    @(posedge PCLK); #1;
    check("midrst_pre_penable", {31'd0, PENABLE}, 32'd1);
    PRESETn = 1'b0;
    #1;
    check("midrst_psel",    {28'd0, PSEL},      32'd0);
    check("midrst_penable", {31'd0, PENABLE},   32'd0);
    check("midrst_ready",   {31'd0, cpu_ready}, 32'd0);
    check("midrst_busy",    {31'd0, cpu_busy},  32'd0);
    @(posedge PCLK); #1;
    PRESETn  = 1'b1;
    stall[3] = 0;
    xfer("post_rst", 1'b1, 16'hF07E, 16'h1234, 4'b1000, 16'h0000, 1'b0, 1);

    // A second request held high while busy must not start another transfer.
    @(posedge PCLK); #1;
    cpu_req   = 1'b1;
    cpu_we    = 1'b0;
    cpu_addr  = 16'hF05F;
    sb_q.push_back({16'h5A5A, 1'b0});
    @(posedge PCLK); #1;
    cpu_we    = 1'b1;
    cpu_addr  = 16'hF01E;
    cpu_wdata = 16'hCAFE;
    setups    = (PSEL != 4'd0 && !PENABLE) ? 1 : 0;
    sel0_seen = PSEL[0];
    readies   = 0;
    cyc       = 0;
    while (readies == 0 && cyc < 30) begin
      @(posedge PCLK); #1;
      cyc++;
      if (PSEL != 4'd0 && !PENABLE) setups++;
      sel0_seen = sel0_seen | PSEL[0];
      if (cpu_ready) begin
        readies++;
        cpu_req = 1'b0;
      end
    end
    for (int k = 0; k < 4; k++) begin
      @(posedge PCLK); #1;
      if (PSEL != 4'd0 && !PENABLE) setups++;
      if (cpu_ready) readies++;
      sel0_seen = sel0_seen | PSEL[0];
    end
    check("busy_setups",    setups,             32'd1);
    check("busy_readies",   readies,            32'd1);
    check("busy_sel0",      {31'd0, sel0_seen}, 32'd0);
    check("busy_idle_flag", {31'd0, cpu_busy},  32'd0);

    @(posedge PCLK); #1;
    check("sb_drained", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Upstream neighbour of the GPIO peripheral: converts single-cycle CPU load/store requests into APB two-phase (SETUP/ACCESS) transfers.
- Decodes the peripheral region into one-hot PSEL lines and returns read data and completion to the CPU.
- Sits between the SimpleRisc core's memory-mapped I/O port and the APB slaves (GPIO, timers, UART).
- Adds PREADY support with a timeout, so a dead slave cannot hang the core.

Parameters:
- NUM_SLAVES, 4: number of APB slaves (PSEL width). Must be ≤ 2^SEL_BITS.
- SEL_BITS, 2: address bits [5+SEL_BITS-1:5] select the slave.
- APB_REGION, 4'hF: value of cpu_addr[15:12] that maps to APB space.
- TIMEOUT, 16: maximum ACCESS-phase cycles waiting for PREADY. Must be ≥ 2.

Ports:
- PCLK  in  1  clock; all logic on its rising edge.
- PRESETn  in  1  asynchronous, active-low reset.
- cpu_req  in  1  request strobe; sampled only in IDLE.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  16  byte/word address.
- cpu_wdata  in  16  store data.
- cpu_rdata  out  16  load data; valid when cpu_ready=1.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_err  out  1  qualifies cpu_ready; 1 = decode error or timeout.
- cpu_busy  out  1  1 whenever the FSM is not IDLE.
- PADDR  out  5  slave register offset (cpu_addr[4:0]).
- PWRITE  out  1  transfer direction.
- PWDATA  out  16  write data.
- PSEL  out  NUM_SLAVES  one-hot slave select.
- PENABLE  out  1  ACCESS-phase indicator.
- PRDATA_bus  in  NUM_SLAVES*16  concatenated slave read data; slave i occupies [16i+15:16i].
- PREADY  in  NUM_SLAVES  per-slave ready. Slaves without PREADY (e.g. GPIO) are tied to 1.

Behaviour:
- Reset values:
  - All outputs 0; FSM in IDLE; timeout counter 0.
  - Reset mid-transfer aborts immediately: PSEL and PENABLE drop asynchronously and no cpu_ready is issued.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - On cpu_req=1, latch cpu_we, cpu_addr and cpu_wdata into internal registers. All APB outputs are driven from these registers, never from cpu_* directly.
  - Decode: hit = (addr[15:12]==APB_REGION) and (slave index < NUM_SLAVES).
  - hit → SETUP. Miss → RESP with error, and no APB activity.
- SETUP (exactly 1 cycle): PSEL[idx]=1, PENABLE=0, PADDR/PWRITE/PWDATA valid → ACCESS.
- ACCESS:
  - PSEL held, PENABLE=1.
  - PREADY[idx]=1 → capture PRDATA_bus slice idx (loads only; stores capture 0) → RESP with err=0.
  - Timeout counter increments each ACCESS cycle while PREADY=0. Reaching TIMEOUT-1 without PREADY → RESP with err=1 and rdata=0.
  - Counter clears on entry to SETUP.
- RESP (1 cycle):
  - PSEL=0, PENABLE=0; cpu_ready=1 and cpu_err registered; cpu_rdata holds captured data → IDLE.
  - cpu_rdata keeps its value until the next RESP.
- Latency with PREADY tied high: req edge N → SETUP at N+1 → ACCESS at N+2 → cpu_ready at N+3.
- Decode miss: cpu_ready one cycle after the request edge.
- cpu_req in any state other than IDLE is ignored. The core must hold off via cpu_busy; there is no queueing.
- Back-to-back: a request may be accepted in the IDLE cycle immediately following RESP.
- Between transfers, PADDR/PWRITE/PWDATA keep their last values. PSEL is always 0 outside SETUP/ACCESS.
- At most one PSEL bit is ever set.

Test Plan:
- Store addr 16'hF01E, data 16'h00FF, PREADY=1 → SETUP with PSEL=4'b0001, PADDR=5'h1E, PWRITE=1, PWDATA=16'h00FF, PENABLE=0; next cycle PENABLE=1; cpu_ready with err=0 at the 3rd edge after the request.
- Load addr 16'hF03F with slave 1 driving PRDATA=16'hA5C3 → PSEL=4'b0010, PWRITE=0; cpu_rdata=16'hA5C3, err=0.
- Slave 2 holds PREADY low for 3 ACCESS cycles (addr 16'hF05F) → PENABLE stays high for 4 cycles; completion with err=0 and no early cpu_ready.
- PREADY stuck low, TIMEOUT=16 → ACCESS lasts 16 cycles, then cpu_ready with err=1 and rdata=0; PSEL returns to 0.
- Address 16'h1234 (region miss) → no PSEL ever asserted; cpu_ready with err=1 one cycle later.
- PRESETn pulsed low during ACCESS → PSEL, PENABLE and cpu_ready are 0 immediately; after release, a fresh store completes normally. Also: a second cpu_req asserted while busy is ignored, so exactly one APB transfer occurs.
